load_store_unit: RTL
====================

# load_store_unit

Memory-stage load/store unit sitting directly upstream of `dmem`. It accepts one load or store request from the pipeline memory stage and converts it into word-aligned `dmem` read/write cycles. `dmem` has no byte strobes, so byte and halfword stores are done as read-modify-write. Loaded data is extracted and sign- or zero-extended little-endian, and misaligned or illegal accesses are reported through `resp_err`.

## Interface
- `XLEN`, 32: data and address width; only 32 is supported.
- `clk`  in  1  clock; everything is sampled on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle and able to accept a request.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW).
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned access or illegal funct3.
- `mem_addr`  out  32  word address to `dmem`; bits [1:0] always 0.
- `mem_rd_en`  out  1  `dmem` read enable.
- `mem_wr_en`  out  1  `dmem` write enable.
- `mem_wdata`  out  32  `dmem` write data.
- `mem_rdata`  in  32  `dmem` read data, valid the cycle after `mem_rd_en`.

## Operation
- States: IDLE, RD, RDWAIT, WR, RESP. With `LSU_MISALIGNED_EN` defined, RD2 and RDWAIT2 are added.
- A request is accepted when `req_valid && req_ready`. `req_ready` is 1 only in IDLE, and the request fields are captured into registers on acceptance.
- Legal funct3 for loads: 000, 001, 010, 100, 101. Legal funct3 for stores: 000, 001, 010. Any other value goes IDLE→RESP with `resp_err`=1 and no memory access.
- Misaligned access: LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
  - Stores always report an error.
  - Loads report an error unless the macro is defined.
  - Errored accesses go IDLE→RESP and make no memory access.
- Load: IDLE→RD (`mem_rd_en`=1) →RDWAIT (capture `mem_rdata`) →RESP. Byte/halfword lane is selected by `addr[1:0]`, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- SW: IDLE→WR (`mem_wr_en`=1, `mem_wdata`=`req_wdata`) →RESP. No read is issued.
- SB/SH: IDLE→RD→RDWAIT, where the captured word is merged with `wdata[7:0]` or `wdata[15:0]` at the `addr[1:0]` lane. Then →WR→RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then →IDLE. There is no response backpressure.
- All `mem_*` and `resp_*` outputs are registered. `mem_rd_en` and `mem_wr_en` are never both 1, and each is high for exactly one cycle per access.

## Timing
- Cycle 0 is the acceptance edge.
- Aligned load: `mem_rd_en` in c1, `resp_valid` in c3.
- SW: `mem_wr_en` in c1, `resp_valid` in c2.
- SB/SH: `mem_rd_en` in c1, `mem_wr_en` in c3, `resp_valid` in c4.
- Error: `resp_valid`/`resp_err` in c1.
- Throughput: `req_ready` returns in the cycle after RESP.
- Reset values:
  - state IDLE.
  - `req_ready`=1.
  - `resp_valid`, `resp_err`, `mem_rd_en`, `mem_wr_en` = 0.
  - `resp_rdata`, `mem_addr`, `mem_wdata` = 0.
- Reset mid-operation aborts at the reset edge: no later `mem_wr_en` and no `resp_valid` for the aborted request. A write already issued before reset stands.

## Configuration
- `LSU_MISALIGNED_EN` defined: misaligned loads are served.
  - If the access lies within one word: a single read with lane shift (LH at offset 1 uses bytes 1–2).
  - If it straddles a word boundary: RD→RDWAIT→RD2 (address +4, wrapping 0xFFFFFFFC→0x00000000) →RDWAIT2→RESP, with the result assembled from both words. `resp_valid` arrives in c5.
- `LSU_MISALIGNED_EN` undefined: every misaligned load returns `resp_err`=1 with no access.
- Misaligned stores return an error in both configurations.

## Structure
- `lsu_pkg`: state enum; funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`); `WORD_BYTES`=4.
- Sub-module `lsu_align`, purely combinational: load lane extract and extension (including two-word assembly under the macro), and store byte/halfword merge. The top level holds the FSM and registers.

## Test plan
- Word 0x100 = 0x87654321. LB 0x103 → `resp_rdata` 0xFFFFFF87 in c3; LBU 0x103 → 0x00000087; LHU 0x102 → 0x00008765.
- SB 0x101 with `wdata` 0x000000AA → `mem_rd_en` c1 at 0x100; `mem_wr_en` c3 at 0x100 with `mem_wdata` 0x8765AA21; `resp_valid` c4 with `resp_err`=0.
- SW 0x104 with 0xDEADBEEF → `mem_wr_en` c1, `resp_valid` c2; `mem_rd_en` never asserted.
- Word 0x104 = 0xDEADBEEF, LW 0x102:
  - without the macro → `resp_err`=1 in c1, no `mem_*` activity;
  - with the macro → reads 0x100 then 0x104, `resp_rdata` 0xBEEF8765 in c5.
- Load with funct3 011, and SH 0x101 → `resp_err`=1 in c1, `resp_rdata` 0, no memory access.
- `rst` asserted in the RDWAIT cycle of an SB → no `mem_wr_en`, no `resp_valid`, `req_ready`=1 after the reset edge; a following LW is served normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// RV32I load/store funct3 codes and the word-alignment helper.
// Optional feature macro: LSU_MISALIGNED_EN (adds the RD2/RDWAIT2 states).
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_RDWAIT  = 3'd2,
        S_WR      = 3'd3,
        S_RESP    = 3'd4,
        S_RD2     = 3'd5,
        S_RDWAIT2 = 3'd6
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int WORD_BYTES = 4;

    // Clear the byte-offset bits so the address points at its containing word.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~(32'(WORD_BYTES - 1));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment for the load/store unit.
// Load path: shifts the (optionally two-word) read data down by the byte
// offset, then sign- or zero-extends according to funct3.
// Store path: merges a byte/halfword into the word read back from dmem.
// i_word_hi is only non-zero for word-straddling loads (LSU_MISALIGNED_EN).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word_lo,
    input  logic [31:0] i_word_hi,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_data
);

    logic [4:0]  w_sh;
    logic [5:0]  w_shc;
    logic [31:0] w_seg;
    logic [31:0] w_mask;

    // Load lane extraction across {hi, lo} followed by extension.
    always_comb begin
        w_sh  = {i_offset, 3'b000};
        w_shc = 6'd32 - {1'b0, w_sh};
        w_seg = (i_word_lo >> w_sh) | ((w_sh == 5'd0) ? 32'd0 : (i_word_hi << w_shc));
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_seg[7]}}, w_seg[7:0]};
            F3_H:    o_load_data = {{16{w_seg[15]}}, w_seg[15:0]};
            F3_W:    o_load_data = w_seg;
            F3_BU:   o_load_data = {24'd0, w_seg[7:0]};
            F3_HU:   o_load_data = {16'd0, w_seg[15:0]};
            default: o_load_data = 32'd0;
        endcase
    end

    // Store merge: replace only the addressed lane of the old word.
    always_comb begin
        case (i_funct3)
            F3_B:    w_mask = 32'h0000_00FF << w_sh;
            F3_H:    w_mask = 32'h0000_FFFF << w_sh;
            default: w_mask = 32'hFFFF_FFFF;
        endcase
        o_store_data = (i_word_lo & ~w_mask) | ((i_wdata << w_sh) & w_mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit in front of a strobe-less dmem.
// Loads: read word, extract lane, extend. SW: direct write.
// SB/SH: read-modify-write. Illegal funct3 and misaligned accesses respond
// with o_resp_err and no memory traffic.
// Optional feature macro: LSU_MISALIGNED_EN -- serves misaligned loads,
// using a second read (RD2/RDWAIT2) when the access straddles two words.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_store,
    input  logic [2:0]      i_req_funct3,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    output logic            o_resp_valid,
    output logic [XLEN-1:0] o_resp_rdata,
    output logic            o_resp_err,
    output logic [XLEN-1:0] o_mem_addr,
    output logic            o_mem_rd_en,
    output logic            o_mem_wr_en,
    output logic [XLEN-1:0] o_mem_wdata,
    input  logic [XLEN-1:0] i_mem_rdata
);

    lsu_state_e      r_state;
    logic            r_store;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;
    logic [XLEN-1:0] r_wdata;

    logic            r_resp_valid;
    logic            r_resp_err;
    logic [XLEN-1:0] r_resp_rdata;
    logic [XLEN-1:0] r_mem_addr;
    logic            r_mem_rd_en;
    logic            r_mem_wr_en;
    logic [XLEN-1:0] r_mem_wdata;

    logic            w_legal;
    logic            w_misal;
    logic            w_err;
    logic [XLEN-1:0] w_word_lo;
    logic [XLEN-1:0] w_word_hi;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_store_data;

`ifdef LSU_MISALIGNED_EN
    logic [XLEN-1:0] r_word_lo;
    logic            w_straddle;

    // A misaligned halfword at offset 3 or a misaligned word crosses into the next word.
    always_comb begin
        w_straddle = ((r_f3[1:0] == 2'b01) && (r_off == 2'b11)) ||
                     ((r_f3[1:0] == 2'b10) && (r_off != 2'b00));
    end

    // Second word comes straight from dmem; the first was parked in r_word_lo.
    always_comb begin
        if (r_state == S_RDWAIT2) begin
            w_word_lo = r_word_lo;
            w_word_hi = i_mem_rdata;
        end else begin
            w_word_lo = i_mem_rdata;
            w_word_hi = '0;
        end
    end
`else
    // Single-word accesses only: the upper word never contributes.
    always_comb begin
        w_word_lo = i_mem_rdata;
        w_word_hi = '0;
    end
`endif

    // Decode legality and alignment of the request presented in IDLE.
    always_comb begin
        if (i_req_store)
            w_legal = (i_req_funct3 == F3_B) || (i_req_funct3 == F3_H) || (i_req_funct3 == F3_W);
        else
            w_legal = (i_req_funct3 == F3_B)  || (i_req_funct3 == F3_H) || (i_req_funct3 == F3_W) ||
                      (i_req_funct3 == F3_BU) || (i_req_funct3 == F3_HU);
        w_misal = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                  ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGNED_EN
        w_err = !w_legal || (w_misal && i_req_store);
`else
        w_err = !w_legal || w_misal;
`endif
    end

    lsu_align u_align (
        .i_word_lo    (w_word_lo),
        .i_word_hi    (w_word_hi),
        .i_offset     (r_off),
        .i_funct3     (r_f3),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_data (w_store_data)
    );

    // Main FSM with registered memory and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_addr   <= '0;
            r_mem_rd_en  <= 1'b0;
            r_mem_wr_en  <= 1'b0;
            r_mem_wdata  <= '0;
        end else begin
            // Enables and the response strobe are single-cycle pulses.
            r_mem_rd_en  <= 1'b0;
            r_mem_wr_en  <= 1'b0;
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_store <= i_req_store;
                        r_f3    <= i_req_funct3;
                        r_off   <= i_req_addr[1:0];
                        r_wdata <= i_req_wdata;
                        if (w_err) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                            r_state      <= S_RESP;
                        end else if (i_req_store && (i_req_funct3 == F3_W)) begin
                            r_mem_wr_en <= 1'b1;
                            r_mem_addr  <= word_align(i_req_addr);
                            r_mem_wdata <= i_req_wdata;
                            r_state     <= S_WR;
                        end else begin
                            r_mem_rd_en <= 1'b1;
                            r_mem_addr  <= word_align(i_req_addr);
                            r_state     <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    r_state <= S_RDWAIT;
                end
                S_RDWAIT: begin
                    if (r_store) begin
                        r_mem_wr_en <= 1'b1;
                        r_mem_wdata <= w_store_data;
                        r_state     <= S_WR;
`ifdef LSU_MISALIGNED_EN
                    end else if (w_straddle) begin
                        r_word_lo   <= i_mem_rdata;
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= r_mem_addr + XLEN'(WORD_BYTES);
                        r_state     <= S_RD2;
`endif
                    end else begin
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= w_load_data;
                        r_state      <= S_RESP;
                    end
                end
`ifdef LSU_MISALIGNED_EN
                S_RD2: begin
                    r_state <= S_RDWAIT2;
                end
                S_RDWAIT2: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= w_load_data;
                    r_state      <= S_RESP;
                end
`endif
                S_WR: begin
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    r_resp_err <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready  = (r_state == S_IDLE);
    assign o_resp_valid = r_resp_valid;
    assign o_resp_err   = r_resp_err;
    assign o_resp_rdata = r_resp_rdata;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_rd_en  = r_mem_rd_en;
    assign o_mem_wr_en  = r_mem_wr_en;
    assign o_mem_wdata  = r_mem_wdata;

endmodule
